// File: rtl/mem_arbiter_pkg.sv
// Shared types for the IF/MEM single-port SRAM arbiter.
// State and owner encodings plus the requester-side word width.
package mem_arbiter_pkg;

   localparam int WORD_WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   typedef enum logic {
      FETCH = 1'b0,
      DATA  = 1'b1
   } owner_t;

endpackage

// File: rtl/mem_wait_counter.sv
// Loadable down-counter that times one SRAM access.
// Stops at zero; zero flag marks the final access cycle.
module mem_wait_counter #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             en,
   output logic             zero
);

   logic [WIDTH-1:0] cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (en && cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a multi-cycle single-port SRAM between fetch and data.
// Returns read data with a one-cycle ready pulse and drives freezes.
module mem_arbiter #(
   parameter int WORD_WIDTH      = mem_arbiter_pkg::WORD_WIDTH,
   parameter int SRAM_ADDR_WIDTH = 17,
   parameter int WAIT_CYCLES     = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       if_req,
   input  logic [WORD_WIDTH-1:0]      if_addr,
   output logic [WORD_WIDTH-1:0]      if_rdata,
   output logic                       if_ready,
   input  logic                       mem_rd,
   input  logic                       mem_wr,
   input  logic [WORD_WIDTH-1:0]      mem_addr,
   input  logic [WORD_WIDTH-1:0]      mem_wdata,
   output logic [WORD_WIDTH-1:0]      mem_rdata,
   output logic                       mem_ready,
   output logic                       sram_cs,
   output logic                       sram_we,
   output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
   output logic [WORD_WIDTH-1:0]      sram_wdata,
   input  logic [WORD_WIDTH-1:0]      sram_rdata,
   output logic                       freeze_if,
   output logic                       freeze_pipe
);

   import mem_arbiter_pkg::*;

   localparam logic [3:0] LOAD_VAL = 4'(WAIT_CYCLES - 1);

   state_t state;
   owner_t owner;
   owner_t last_grant;
   owner_t pick;
   logic   data_req;
   logic   any_req;
   logic   cnt_zero;
   logic   unused_addr_bits;

   assign data_req = mem_rd | mem_wr;
   assign any_req  = if_req | data_req;

   // Data normally wins; after a data grant fetch gets its turn.
   assign pick = (data_req && (!if_req || last_grant == FETCH))
               ? DATA : FETCH;

   assign freeze_if   = if_req & ~if_ready;
   assign freeze_pipe = data_req & ~mem_ready;

   assign unused_addr_bits = ^{
      if_addr[1:0], if_addr[WORD_WIDTH-1:SRAM_ADDR_WIDTH+2],
      mem_addr[1:0], mem_addr[WORD_WIDTH-1:SRAM_ADDR_WIDTH+2]
   };

   mem_wait_counter #(.WIDTH(4)) u_wait (
      .clk      (clk),
      .rst      (rst),
      .load     (state == IDLE && any_req),
      .load_val (LOAD_VAL),
      .en       (state == ACCESS),
      .zero     (cnt_zero)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         owner      <= FETCH;
         last_grant <= DATA;
         sram_cs    <= 1'b0;
         sram_we    <= 1'b0;
         sram_addr  <= '0;
         sram_wdata <= '0;
         if_ready   <= 1'b0;
         mem_ready  <= 1'b0;
         if_rdata   <= '0;
         mem_rdata  <= '0;
      end else begin
         if_ready  <= 1'b0;
         mem_ready <= 1'b0;
         unique case (state)
            IDLE: begin
               if (any_req) begin
                  owner      <= pick;
                  last_grant <= pick;
                  sram_cs    <= 1'b1;
                  sram_we    <= (pick == DATA) && mem_wr;
                  sram_addr  <= (pick == DATA)
                              ? mem_addr[SRAM_ADDR_WIDTH+1:2]
                              : if_addr[SRAM_ADDR_WIDTH+1:2];
                  sram_wdata <= mem_wdata;
                  state      <= ACCESS;
               end
            end
            ACCESS: begin
               if (cnt_zero) begin
                  sram_cs <= 1'b0;
                  sram_we <= 1'b0;
                  state   <= DONE;
                  // A withdrawn request still gets its data, but no ready.
                  if (owner == FETCH) begin
                     if_rdata <= sram_rdata;
                     if_ready <= if_req;
                  end else begin
                     if (!sram_we) mem_rdata <= sram_rdata;
                     mem_ready <= data_req;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
